imm_decode_sequencer: RTL and testbench
=======================================

Name: imm_decode_sequencer

Overview:
- Multi-cycle decode controller in front of the immediate sign-extender.
- Accepts instructions over a valid/ready handshake and classifies the opcode into the 3-bit immediate type.
- Drives the sign-extender's instruction and type inputs for one dedicated cycle, captures the returned 32-bit immediate, and presents instruction, type and immediate to execute over a second valid/ready handshake.
- Counts issued and unsupported instructions for debug.

Parameters:
CNT_W, 16, width of the issued and unsupported instruction counters (saturating)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  sequencer can accept an instruction this cycle
in_inst  input  32  instruction word from fetch
sext_inst  output  32  instruction word driven to the sign-extender
sext_imm_type  output  3  immediate type driven to the sign-extender
sext_imm  input  32  combinational immediate returned by the sign-extender
out_valid  output  1  decoded bundle valid to execute
out_ready  input  1  execute accepts the bundle
out_inst  output  32  registered instruction word
out_imm_type  output  3  registered immediate type
out_imm  output  32  registered extended immediate
out_unsupported  output  1  opcode not handled by this datapath
issued_cnt  output  CNT_W  bundles accepted by execute, saturating
unsup_cnt  output  CNT_W  unsupported bundles accepted, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All registered outputs, counters, sext_inst and sext_imm_type clear to 0.
  - in_ready=1 and out_valid=0 on the first cycle after release.
- Classification uses opcode inst[6:0], registered on capture:
  - 0000011 (LOAD), 0010011 (OP-IMM), 1100111 (JALR): type 000 (I).
  - 0100011 (STORE): type 001 (S).
  - 0110011 (OP): type 010 (none).
  - Any other opcode: type 010 with unsupported=1.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: capture inst_q and type_q, go to EXT.
- State EXT:
  - in_ready=0, out_valid=0.
  - sext_inst=inst_q and sext_imm_type=type_q.
  - Capture sext_imm into imm_q at the end of the cycle and go to HOLD.
  - sext_* hold their last values in every other state; no glitching to 0.
- State HOLD:
  - out_valid=1. out_inst, out_imm_type, out_imm and out_unsupported are stable until the handshake completes.
  - in_ready equals out_ready (combinational pass-through).
  - out_ready=1 and in_valid=1: bundle retires and the new instruction is captured the same cycle; go to EXT.
  - out_ready=1 and in_valid=0: go to IDLE.
  - out_ready=0: stay in HOLD; in_valid is ignored and the upstream instruction is not consumed.
- Latency: instruction accepted in cycle N gives out_valid in cycle N+2. Sustained throughput is one bundle per 2 cycles.
- Counters:
  - issued_cnt increments on every out_valid and out_ready cycle.
  - unsup_cnt increments on the same condition when out_unsupported=1.
  - Both saturate at 2^CNT_W-1; no wrap.
- Type encodings 011–111 are never driven.
- Reset asserted mid-operation (EXT or HOLD): the in-flight bundle is discarded, counters clear, and there is no out_valid pulse after release.
- out_valid never deasserts without a handshake; the bundle payload is registered, not combinational from in_inst.

Test Plan:
- Reset then in_inst=0xFFF00093 (addi x1,x0,-1) with real extender and out_ready=1:
  - out_valid two cycles after acceptance.
  - out_imm_type=000, out_imm=0xFFFFFFFF, out_unsupported=0, issued_cnt=1.
- in_inst=0xFE20AE23 (sw x2,-4(x1)): sext_imm_type=001 during EXT; out_imm=0xFFFFFFFC.
- in_inst=0x002081B3 (add): out_imm_type=010 and out_imm=0. Then in_inst=0x12345037 (lui): out_unsupported=1, unsup_cnt=1.
- Backpressure:
  - out_ready=0 for 5 cycles in HOLD while in_valid=1 with a second instruction: outputs stable, in_ready=0.
  - On out_ready=1 the second instruction is captured the same cycle and appears 2 cycles later.
- Assert rst low while in EXT: all outputs are 0 immediately. After release, in_ready=1 and no spurious out_valid.
- CNT_W=2, 5 back-to-back bundles accepted: issued_cnt saturates at 3.

Source files
------------

// File: rtl/imm_decode_sequencer_if.sv
// Handshake and bus signals between fetch, the sign-extender and execute
// for the immediate decode sequencer.
interface imm_decode_sequencer_if;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned TYPE_W = 3;

  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_inst;
  logic [XLEN-1:0]   sext_inst;
  logic [TYPE_W-1:0] sext_imm_type;
  logic [XLEN-1:0]   sext_imm;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_inst;
  logic [TYPE_W-1:0] out_imm_type;
  logic [XLEN-1:0]   out_imm;
  logic              out_unsupported;

  modport slave (
    input  in_valid, in_inst, sext_imm, out_ready,
    output in_ready, sext_inst, sext_imm_type,
           out_valid, out_inst, out_imm_type, out_imm, out_unsupported
  );

  modport master (
    output in_valid, in_inst, sext_imm, out_ready,
    input  in_ready, sext_inst, sext_imm_type,
           out_valid, out_inst, out_imm_type, out_imm, out_unsupported
  );
endinterface

// File: rtl/imm_decode_sequencer.sv
// Multi-cycle decode controller: classifies the opcode, drives the sign-extender
// for one cycle, and hands the registered bundle to execute.
module imm_decode_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  imm_decode_sequencer_if.slave bus,
  output logic [CNT_W-1:0]      issued_cnt,
  output logic [CNT_W-1:0]      unsup_cnt
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned TYPE_W = 3;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  localparam logic [TYPE_W-1:0] TYPE_I    = 3'b000;
  localparam logic [TYPE_W-1:0] TYPE_S    = 3'b001;
  localparam logic [TYPE_W-1:0] TYPE_NONE = 3'b010;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXT  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0]   inst_q;
  logic [TYPE_W-1:0] type_q;
  logic              unsup_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   out_inst_q;
  logic [TYPE_W-1:0] out_type_q;
  logic [XLEN-1:0]   out_imm_q;
  logic              out_unsup_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  unsup_cnt_q;

  logic [TYPE_W-1:0] cls_type_c;
  logic              cls_unsup_c;
  logic              capture_c;
  logic              load_out_c;
  logic              ready_c;
  logic              retire_c;

  // Opcode classification of the incoming instruction
  always_comb begin
    cls_type_c  = TYPE_NONE;
    cls_unsup_c = 1'b0;
    case (bus.in_inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR: cls_type_c = TYPE_I;
      OP_STORE:                 cls_type_c = TYPE_S;
      OP_OP:                    cls_type_c = TYPE_NONE;
      default:                  cls_unsup_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    capture_c  = 1'b0;
    load_out_c = 1'b0;
    ready_c    = 1'b0;
    case (state)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.in_valid) begin
          capture_c = 1'b1;
          state_nxt = S_EXT;
        end
      end
      S_EXT: begin
        load_out_c = 1'b1;
        state_nxt  = S_HOLD;
      end
      S_HOLD: begin
        // Upstream sees execute's ready so a retire can overlap the next capture
        ready_c = bus.out_ready;
        if (bus.out_ready) begin
          capture_c = bus.in_valid;
          state_nxt = bus.in_valid ? S_EXT : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign retire_c = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q      <= '0;
      type_q      <= '0;
      unsup_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_type_q  <= '0;
      out_imm_q   <= '0;
      out_unsup_q <= 1'b0;
      issued_q    <= '0;
      unsup_cnt_q <= '0;
    end else begin
      if (capture_c) begin
        inst_q  <= bus.in_inst;
        type_q  <= cls_type_c;
        unsup_q <= cls_unsup_c;
      end
      if (load_out_c) begin
        out_valid_q <= 1'b1;
        out_inst_q  <= inst_q;
        out_type_q  <= type_q;
        out_imm_q   <= bus.sext_imm;
        out_unsup_q <= unsup_q;
      end else if (retire_c) begin
        out_valid_q <= 1'b0;
      end
      // Saturating debug counters
      if (retire_c) begin
        if (issued_q != CNT_MAX) issued_q <= issued_q + CNT_W'(1);
        if (out_unsup_q && (unsup_cnt_q != CNT_MAX)) unsup_cnt_q <= unsup_cnt_q + CNT_W'(1);
      end
    end
  end

  // in_ready is forced low while reset is asserted so every output reads 0
  assign bus.in_ready        = rst & ready_c;
  assign bus.sext_inst       = inst_q;
  assign bus.sext_imm_type   = type_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_inst        = out_inst_q;
  assign bus.out_imm_type    = out_type_q;
  assign bus.out_imm         = out_imm_q;
  assign bus.out_unsupported = out_unsup_q;
  assign issued_cnt          = issued_q;
  assign unsup_cnt           = unsup_cnt_q;
endmodule

// File: tb/tb_imm_decode_sequencer.sv
// Bench for imm_decode_sequencer: transaction-level model with per-cycle compare
// plus directed vectors with literal expectations.
module tb_imm_decode_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        out_ready;
  logic [15:0] issued_cnt, unsup_cnt;
  logic [1:0]  issued_b, unsup_b;

  int nvec = 0;
  int nerr = 0;
  int ecount = 0;
  int m_issued = 0;
  int m_unsup = 0;

  typedef struct {
    logic [31:0] inst;
    int          acc;
  } item_t;
  item_t q[$];

  imm_decode_sequencer_if bus_a();
  imm_decode_sequencer_if bus_b();

  imm_decode_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus_a), .issued_cnt(issued_cnt), .unsup_cnt(unsup_cnt)
  );
  imm_decode_sequencer #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus_b), .issued_cnt(issued_b), .unsup_cnt(unsup_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  // Behavioural sign-extender standing in for the real block
  function automatic logic [31:0] sext_f(input logic [31:0] i, input logic [2:0] t);
    case (t)
      3'b000:  return {{20{i[31]}}, i[31:20]};
      3'b001:  return {{20{i[31]}}, i[31:25], i[11:7]};
      default: return 32'h0;
    endcase
  endfunction

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_inst   = in_inst;
  assign bus_a.out_ready = out_ready;
  assign bus_a.sext_imm  = sext_f(bus_a.sext_inst, bus_a.sext_imm_type);
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_inst   = in_inst;
  assign bus_b.out_ready = out_ready;
  assign bus_b.sext_imm  = sext_f(bus_b.sext_inst, bus_b.sext_imm_type);

  function automatic bit m_known(input logic [31:0] i);
    return i[6:0] inside {7'h03, 7'h13, 7'h67, 7'h23, 7'h33};
  endfunction

  function automatic logic [2:0] m_type(input logic [31:0] i);
    if (i[6:0] inside {7'h03, 7'h13, 7'h67}) return 3'd0;
    if (i[6:0] == 7'h23) return 3'd1;
    return 3'd2;
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] i);
    logic signed [11:0] s;
    case (m_type(i))
      3'd0: return 32'($signed(i) >>> 20);
      3'd1: begin s = {i[31:25], i[11:7]}; return 32'(s); end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the transaction model
  always @(negedge clk) begin
    bit ev, ext, er;
    item_t it;
    if (rst !== 1'b1) begin
      q.delete();
      m_issued = 0;
      m_unsup  = 0;
    end else begin
      ev  = (q.size() > 0) && (ecount >= q[0].acc + 1);
      ext = (q.size() > 0) && (ecount == q[0].acc);
      er  = (q.size() == 0) ? 1'b1 : (ev ? out_ready : 1'b0);
      chk("m_out_valid", bus_a.out_valid, ev);
      chk("m_in_ready", bus_a.in_ready, er);
      chk("m_issued", issued_cnt, sat(m_issued, 65535));
      chk("m_unsup", unsup_cnt, sat(m_unsup, 65535));
      chk("m_issued_sat", issued_b, sat(m_issued, 3));
      chk("m_unsup_sat", unsup_b, sat(m_unsup, 3));
      chk("m_sat_valid", bus_b.out_valid, ev);
      if (ev) begin
        chk("m_out_inst", bus_a.out_inst, q[0].inst);
        chk("m_out_type", bus_a.out_imm_type, m_type(q[0].inst));
        chk("m_out_imm", bus_a.out_imm, m_imm(q[0].inst));
        chk("m_out_unsup", bus_a.out_unsupported, !m_known(q[0].inst));
      end
      if (ext) begin
        chk("m_sext_inst", bus_a.sext_inst, q[0].inst);
        chk("m_sext_type", bus_a.sext_imm_type, m_type(q[0].inst));
      end
      if (ev && out_ready) begin
        if (!m_known(q[0].inst)) m_unsup++;
        m_issued++;
        void'(q.pop_front());
      end
      if (in_valid && er) begin
        it.inst = in_inst;
        it.acc  = ecount + 1;
        q.push_back(it);
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction until the sequencer accepts it
  task automatic send(input logic [31:0] inst);
    bit r;
    bit done = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      r = bus_a.in_ready;
      align();
      if (r) done = 1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic run_one(input logic [31:0] inst, input logic [2:0] t,
                         input logic [31:0] imm, input logic u);
    out_ready = 1'b1;
    send(inst);
    @(negedge clk);
    chk("ext_sext_inst", bus_a.sext_inst, inst);
    chk("ext_sext_type", bus_a.sext_imm_type, t);
    chk("ext_out_valid", bus_a.out_valid, 1'b0);
    @(negedge clk);
    chk("hold_out_valid", bus_a.out_valid, 1'b1);
    chk("hold_type", bus_a.out_imm_type, t);
    chk("hold_imm", bus_a.out_imm, imm);
    chk("hold_unsup", bus_a.out_unsupported, u);
    align();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_inst = 32'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus_a.out_valid, 1'b0);
    chk("rst_sext_inst", bus_a.sext_inst, 32'h0);
    chk("rst_issued", issued_cnt, 32'h0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus_a.in_ready, 1'b1);
    chk("post_rst_out_valid", bus_a.out_valid, 1'b0);
    align();

    run_one(32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    chk("addi_issued", issued_cnt, 32'd1);
    chk("addi_idle_valid", bus_a.out_valid, 1'b0);
    align();
    run_one(32'hFE20AE23, 3'd1, 32'hFFFFFFFC, 1'b0);
    run_one(32'h002081B3, 3'd2, 32'h0, 1'b0);
    run_one(32'h12345037, 3'd2, 32'h0, 1'b1);
    @(negedge clk);
    chk("lui_unsup_cnt", unsup_cnt, 32'd1);
    chk("lui_issued", issued_cnt, 32'd4);
    align();

    // Backpressure with a second instruction waiting upstream
    out_ready = 1'b0;
    send(32'h00500113);
    in_valid = 1'b1;
    in_inst  = 32'hFE20AE23;
    @(negedge clk);
    chk("bp_ext_ready", bus_a.in_ready, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", bus_a.out_valid, 1'b1);
      chk("bp_inst", bus_a.out_inst, 32'h00500113);
      chk("bp_imm", bus_a.out_imm, 32'h00000005);
      chk("bp_ready", bus_a.in_ready, 1'b0);
    end
    align();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", bus_a.in_ready, 1'b1);
    align();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp2_sext_inst", bus_a.sext_inst, 32'hFE20AE23);
    chk("bp2_ext_valid", bus_a.out_valid, 1'b0);
    @(negedge clk);
    chk("bp2_valid", bus_a.out_valid, 1'b1);
    chk("bp2_inst", bus_a.out_inst, 32'hFE20AE23);
    chk("bp2_imm", bus_a.out_imm, 32'hFFFFFFFC);
    align();

    // Reset while the sequencer sits in EXT
    send(32'h00A00193);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", bus_a.in_ready, 1'b0);
    chk("mid_rst_out_valid", bus_a.out_valid, 1'b0);
    chk("mid_rst_out_inst", bus_a.out_inst, 32'h0);
    chk("mid_rst_out_imm", bus_a.out_imm, 32'h0);
    chk("mid_rst_sext_inst", bus_a.sext_inst, 32'h0);
    chk("mid_rst_sext_type", bus_a.sext_imm_type, 32'h0);
    chk("mid_rst_issued", issued_cnt, 32'h0);
    chk("mid_rst_unsup", unsup_cnt, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("after_rst_ready", bus_a.in_ready, 1'b1);
    chk("after_rst_valid", bus_a.out_valid, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("after_rst_no_valid", bus_a.out_valid, 1'b0);
    end
    align();

    // Back-to-back stream to saturate the 2-bit counters
    out_ready = 1'b1;
    send(32'h00100093);
    send(32'h12345037);
    send(32'h002081B3);
    send(32'hFE20AE23);
    send(32'h0000A083);
    repeat (4) @(negedge clk);
    chk("sat_issued_16", issued_cnt, 32'd5);
    chk("sat_issued_2", issued_b, 32'd3);
    chk("sat_unsup_2", unsup_b, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
